// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory-port arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating grants when both request).
package mem_arb_pkg;

    // Default widths, matching MemAddr / MemValue / ActBit of the ram_uart device
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int ACT_W_DEF  = 16;

    // Transaction sequencing: one request in flight at a time
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Requester identifiers used by the grant picker and the FSM
    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational grant picker for the memory-port arbiter.
// With ARB_ROUND_ROBIN_EN defined, simultaneous requests alternate against
// last_grant; otherwise MEM always wins a tie and last_grant is ignored.
import mem_arb_pkg::*;

module arb_grant_sel (
    input  logic if_req,
    input  logic mem_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority needs no history; the name keeps the unused input quiet
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;
`endif

    // Pick a single requester from the current request lines
    always_comb begin
        grant_valid = if_req | mem_req;
        grant_id    = GRANT_IF;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_req && mem_req) begin
            grant_id = (last_grant == GRANT_IF) ? GRANT_MEM : GRANT_IF;
        end else if (mem_req) begin
            grant_id = GRANT_MEM;
        end
`else
        // MEM holds the older instruction, so it takes precedence
        if (mem_req) begin
            grant_id = GRANT_MEM;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single ram_uart memory/UART port between the instruction-fetch
// and memory-stage requesters. Each transaction carries a fresh act token and
// completes only when the device reports done with that same token.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternating grants on contention).
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACT_W  = ACT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    // Instruction-fetch requester (read only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    // Memory-stage requester
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    // ram_uart device side
    output logic              dev_need_work,
    output logic              dev_rd,
    output logic              dev_wr,
    output logic [ADDR_W-1:0] dev_addr,
    output logic [DATA_W-1:0] dev_wdata,
    output logic [ACT_W-1:0]  dev_act,
    input  logic [ACT_W-1:0]  dev_act_ret,
    input  logic              dev_done,
    input  logic [DATA_W-1:0] dev_rdata,
    // Status
    output logic              busy
);

    localparam logic [ACT_W-1:0] ACT_ONE = {{(ACT_W-1){1'b0}}, 1'b1};

    arb_state_t r_state;
    logic       r_gnt;          // requester owning the transaction in flight
    logic       w_grant_valid;
    logic       w_grant_id;
    logic       w_last_grant;
    logic       w_done_ok;

`ifdef ARB_ROUND_ROBIN_EN
    logic       r_last_grant;
    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = GRANT_IF;
`endif

    arb_grant_sel u_grant_sel (
        .if_req      (if_req),
        .mem_req     (mem_req),
        .last_grant  (w_last_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    // A done pulse only counts when it carries the token we issued
    assign w_done_ok = dev_done && (dev_act_ret == dev_act);

    assign busy = (r_state != ST_IDLE);

    // Transaction FSM with registered device and requester outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_gnt         <= GRANT_IF;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_grant  <= GRANT_IF;
`endif
            if_ack        <= 1'b0;
            mem_ack       <= 1'b0;
            if_rdata      <= '0;
            mem_rdata     <= '0;
            dev_need_work <= 1'b0;
            dev_rd        <= 1'b1;
            dev_wr        <= 1'b0;
            dev_addr      <= '0;
            dev_wdata     <= '0;
            dev_act       <= '0;
        end else begin
            // Acks are single-cycle pulses unless raised below
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Idle bus: RAM bus tri-stated (rd=1), no write
                    dev_need_work <= 1'b0;
                    dev_rd        <= 1'b1;
                    dev_wr        <= 1'b0;
                    if (w_grant_valid) begin
                        r_gnt   <= w_grant_id;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_grant <= w_grant_id;
`endif
                        dev_act <= dev_act + ACT_ONE;
                        if (w_grant_id == GRANT_MEM) begin
                            dev_addr  <= mem_addr;
                            dev_wdata <= mem_wdata;
                            dev_rd    <= ~mem_we;
                            dev_wr    <= mem_we;
                        end else begin
                            dev_addr  <= if_addr;
                            dev_rd    <= 1'b1;
                            dev_wr    <= 1'b0;
                        end
                        dev_need_work <= 1'b1;
                        r_state       <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // Device lines stay frozen until the matching done arrives
                    if (w_done_ok) begin
                        if (!dev_wr) begin
                            if (r_gnt == GRANT_MEM) begin
                                mem_rdata <= dev_rdata;
                            end else begin
                                if_rdata  <= dev_rdata;
                            end
                        end
                        if (r_gnt == GRANT_MEM) begin
                            mem_ack <= 1'b1;
                        end else begin
                            if_ack  <= 1'b1;
                        end
                        dev_need_work <= 1'b0;
                        dev_rd        <= 1'b1;
                        dev_wr        <= 1'b0;
                        r_state       <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // Ack visible this cycle; requests are sampled again in IDLE
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model. A second,
// narrow-token instance exercises act-token wraparound.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [15:0] if_addr, mem_addr, mem_wdata;
    logic [15:0] if_rdata, mem_rdata;
    logic        if_ack, mem_ack;
    logic        dev_need_work, dev_rd, dev_wr, dev_done, busy;
    logic [15:0] dev_addr, dev_wdata, dev_act, dev_act_ret, dev_rdata;

    // Narrow-token instance signals
    logic        wif_req, wmem_req, wmem_we;
    logic [15:0] wif_addr, wmem_addr, wmem_wdata, wif_rdata, wmem_rdata;
    logic        wif_ack, wmem_ack, wneed, wrd, wwr, wdone, wbusy;
    logic [15:0] waddr, wwdata, wdev_rdata;
    logic [3:0]  wact, wact_ret;

    int          n_chk  = 0;
    int          n_fail = 0;

    // Reference model state
    logic [15:0] exp_act, exp_if_rd, exp_mem_rd;
    logic        exp_last;   // 0 = IF, 1 = MEM

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dev_need_work(dev_need_work), .dev_rd(dev_rd), .dev_wr(dev_wr),
        .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_act(dev_act),
        .dev_act_ret(dev_act_ret), .dev_done(dev_done), .dev_rdata(dev_rdata),
        .busy(busy)
    );

    mem_port_arbiter #(.ACT_W(4)) dut_w (
        .clk(clk), .rst(rst),
        .if_req(wif_req), .if_addr(wif_addr), .if_rdata(wif_rdata), .if_ack(wif_ack),
        .mem_req(wmem_req), .mem_we(wmem_we), .mem_addr(wmem_addr), .mem_wdata(wmem_wdata),
        .mem_rdata(wmem_rdata), .mem_ack(wmem_ack),
        .dev_need_work(wneed), .dev_rd(wrd), .dev_wr(wwr),
        .dev_addr(waddr), .dev_wdata(wwdata), .dev_act(wact),
        .dev_act_ret(wact_ret), .dev_done(wdone), .dev_rdata(wdev_rdata),
        .busy(wbusy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    // Arbitration rule: MEM wins ties, or alternation when round-robin is built in
    function automatic logic pick_mem(input logic ir, input logic mr, input logic last);
        if (!mr) return 1'b0;
        if (!ir) return 1'b1;
        if (RR)  return (last == 1'b0);
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst      = 1'b1;
        if_req   = 1'b0;
        mem_req  = 1'b0;
        dev_done = 1'b0;
        step();
        rst        = 1'b0;
        exp_act    = 16'h0000;
        exp_last   = 1'b0;
        exp_if_rd  = 16'h0000;
        exp_mem_rd = 16'h0000;
    endtask

    // Serve one transaction; DUT is in IDLE with requests already presented
    task automatic serve(input int dly, input logic stale, input logic drop,
                         input logic [15:0] rd, output logic g_mem);
        logic        we;
        logic [15:0] ea, ewd;
        g_mem    = pick_mem(if_req, mem_req, exp_last);
        we       = g_mem & mem_we;
        ea       = g_mem ? mem_addr : if_addr;
        ewd      = mem_wdata;
        exp_act  = exp_act + 16'd1;
        exp_last = g_mem;
        step();
        chk("grant_need_work", dev_need_work, 1'b1);
        chk("grant_busy", busy, 1'b1);
        chk("grant_act", dev_act, exp_act);
        chk("grant_addr", dev_addr, ea);
        chk("grant_wr", dev_wr, we);
        chk("grant_rd", dev_rd, !we);
        if (we) chk("grant_wdata", dev_wdata, ewd);
        for (int k = 0; k < dly; k++) begin
            if (stale) begin
                dev_done    = 1'b1;
                dev_act_ret = exp_act - 16'd1;
            end
            step();
            chk("wait_if_ack", if_ack, 1'b0);
            chk("wait_mem_ack", mem_ack, 1'b0);
            chk("wait_need_work", dev_need_work, 1'b1);
            chk("wait_addr", dev_addr, ea);
            chk("wait_wr", dev_wr, we);
        end
        dev_done    = 1'b1;
        dev_act_ret = exp_act;
        dev_rdata   = rd;
        step();
        dev_done    = 1'b0;
        dev_act_ret = 16'($urandom);
        dev_rdata   = 16'($urandom);
        if (!we) begin
            if (g_mem) exp_mem_rd = rd;
            else       exp_if_rd  = rd;
        end
        chk("ack_if", if_ack, !g_mem);
        chk("ack_mem", mem_ack, g_mem);
        chk("ack_if_rdata", if_rdata, exp_if_rd);
        chk("ack_mem_rdata", mem_rdata, exp_mem_rd);
        chk("ack_need_work", dev_need_work, 1'b0);
        chk("ack_rd", dev_rd, 1'b1);
        chk("ack_wr", dev_wr, 1'b0);
        if (drop) begin
            if (g_mem) mem_req = 1'b0;
            else       if_req  = 1'b0;
        end
        step();
        chk("post_if_ack", if_ack, 1'b0);
        chk("post_mem_ack", mem_ack, 1'b0);
        chk("post_busy", busy, 1'b0);
    endtask

    initial begin
        logic       g;
        logic [3:0] seq;
        logic [3:0] et;
        logic [15:0] wd;

        rst = 1'b1;
        if_req = 0; mem_req = 0; mem_we = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        dev_done = 0; dev_act_ret = 0; dev_rdata = 0;
        wif_req = 0; wmem_req = 0; wmem_we = 0;
        wif_addr = 0; wmem_addr = 0; wmem_wdata = 0;
        wdone = 0; wact_ret = 0; wdev_rdata = 0;
        step();
        do_reset();

        // Reset state
        chk("rst_if_ack", if_ack, 1'b0);
        chk("rst_mem_ack", mem_ack, 1'b0);
        chk("rst_if_rdata", if_rdata, 16'h0);
        chk("rst_mem_rdata", mem_rdata, 16'h0);
        chk("rst_need_work", dev_need_work, 1'b0);
        chk("rst_rd", dev_rd, 1'b1);
        chk("rst_wr", dev_wr, 1'b0);
        chk("rst_addr", dev_addr, 16'h0);
        chk("rst_wdata", dev_wdata, 16'h0);
        chk("rst_act", dev_act, 16'h0);
        chk("rst_busy", busy, 1'b0);
        step();
        chk("idle_need_work", dev_need_work, 1'b0);
        chk("idle_rd", dev_rd, 1'b1);

        // IF alone, device answers after 3 cycles
        if_addr = 16'h0040; if_req = 1'b1;
        serve(2, 1'b0, 1'b1, 16'h1234, g);
        chk("t1_act", dev_act, 16'h0001);
        chk("t1_if_rdata", if_rdata, 16'h1234);

        // Simultaneous IF read and MEM write
        do_reset();
        if_addr = 16'h0040; if_req = 1'b1;
        mem_addr = 16'hBF00; mem_wdata = 16'h0041; mem_we = 1'b1; mem_req = 1'b1;
        serve(1, 1'b0, 1'b1, 16'hDEAD, g);
        chk("t2_first_token", dev_act, 16'h0001);
        chk("t2_mem_rdata_kept", mem_rdata, 16'h0000);
        serve(1, 1'b0, 1'b1, 16'h5A5A, g);
        chk("t2_second_token", dev_act, 16'h0002);
        mem_we = 1'b0;

        // Stale done with the old token is ignored
        do_reset();
        if_addr = 16'h0100; if_req = 1'b1;
        serve(4, 1'b1, 1'b1, 16'hBEEF, g);

        // Reset while waiting aborts without an ack
        do_reset();
        if_addr = 16'h0200; if_req = 1'b1;
        step();
        chk("t4_in_wait", dev_need_work, 1'b1);
        do_reset();
        chk("t4_busy", busy, 1'b0);
        chk("t4_need_work", dev_need_work, 1'b0);
        chk("t4_rd", dev_rd, 1'b1);
        chk("t4_act", dev_act, 16'h0);
        chk("t4_if_ack", if_ack, 1'b0);
        dev_done = 1'b1; dev_act_ret = 16'h0001;
        step();
        dev_done = 1'b0;
        chk("t4_no_late_ack", if_ack, 1'b0);
        chk("t4_still_idle", busy, 1'b0);

        // Fairness with both requests held continuously
        do_reset();
        if_addr = 16'h0300; if_req = 1'b1;
        mem_addr = 16'h0400; mem_we = 1'b0; mem_req = 1'b1;
        seq = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            serve(0, 1'b0, 1'b0, 16'($urandom), g);
            seq[3-i] = g;
        end
        if_req = 1'b0; mem_req = 1'b0;
        chk("t5_grant_seq", {28'h0, seq}, RR ? 32'hA : 32'hF);
        do_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 24; n++) begin
            if (!if_req && ($urandom_range(0, 1) == 1)) begin
                if_req  = 1'b1;
                if_addr = 16'($urandom);
            end
            if (!mem_req && ($urandom_range(0, 1) == 1)) begin
                mem_req   = 1'b1;
                mem_we    = 1'($urandom_range(0, 1));
                mem_addr  = 16'($urandom);
                mem_wdata = 16'($urandom);
            end
            if (!if_req && !mem_req) begin
                if_req  = 1'b1;
                if_addr = 16'($urandom);
            end
            serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, 16'($urandom), g);
        end
        if_req = 1'b0; mem_req = 1'b0;
        do_reset();

        // Token wraparound on the narrow-token instance
        for (int i = 0; i < 17; i++) begin
            et = 4'(i + 1);
            wd = 16'($urandom);
            wif_req = 1'b1; wif_addr = 16'($urandom);
            step();
            chk("wrap_act", wact, et);
            wdone = 1'b1; wact_ret = et; wdev_rdata = wd;
            step();
            chk("wrap_ack", wif_ack, 1'b1);
            chk("wrap_rdata", wif_rdata, wd);
            wif_req = 1'b0; wdone = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
